rr_module: RTL and testbench
============================

# rr_module

Self-contained melody player that loops a fixed 16-note "Never Gonna Give You Up" phrase as a 1-bit square-wave audio signal. It is the top design block of the RickRoll project. It has no data ports: it needs only clock and reset, and all behaviour is observed through named internal signals, either hierarchically or in the waveform dump. It is intended as a simulation demo and a tone-sequencer reference.

## Interface
Parameters:
- TICKS_PER_UNIT, 64: clock cycles per duration unit.
- GAP_CYCLES, 4: silent cycles at the end of every note (articulation); must be < TICKS_PER_UNIT.

Ports:
- clock  input  1  sole clock, rising-edge.
- reset  input  1  synchronous, active-high; one clock is sufficient.

Required internal signals (fixed names, probed by verification):
- audio (1): square-wave output.
- note_idx (4): current melody index.
- dur_cnt (12): cycle within the current note.
- tone_cnt (8): cycle within the current half-period.
- loop_count (8): completed passes of the melody.
- note_start (1): one-cycle pulse in the first cycle of each note.

## Operation
Pitch codes (3 bits) and their half-periods in cycles:
- 0 REST: silent.
- 1 A4: 36.
- 2 B4: 32.
- 3 C#5: 29.
- 4 D5: 27.
- 5 E5: 24.
- 6 F#5: 21.
- 7 A5: 18.

Melody ROM, given as index: pitch, units (30 units in total):
- 0–3: A4,1 / B4,1 / D5,1 / B4,1.
- 4–7: F#5,3 / F#5,3 / E5,4 / REST,2.
- 8–11: A4,1 / B4,1 / D5,1 / B4,1.
- 12–15: E5,3 / E5,3 / D5,3 / C#5,1.

Note length is L = units × TICKS_PER_UNIT cycles.

Sequencer:
- dur_cnt increments every cycle.
- When dur_cnt == L−1, the next edge performs a note change:
  - note_idx increments, wrapping 15→0.
  - On the wrap, loop_count increments, wrapping 255→0.
  - dur_cnt, tone_cnt and audio all clear to 0.

Tone generator, "sounding" phase (pitch ≠ REST and dur_cnt < L−GAP_CYCLES):
- tone_cnt increments each cycle.
- When tone_cnt == half−1, audio toggles and tone_cnt clears.

Tone generator, otherwise (rest or gap):
- audio = 0 and tone_cnt = 0.

Other rules:
- note_start = 1 exactly when dur_cnt == 0 (combinational).
- Reset values: note_idx=0, dur_cnt=0, tone_cnt=0, audio=0, loop_count=0.
- Reset always overrides every other action.
- Reset mid-note restarts the melody at index 0 immediately.
- Widths: L is at most 4×64 = 256 under the defaults; dur_cnt is 12 bits, allowing TICKS_PER_UNIT up to 1023. Comparisons are unsigned.

## Timing
- Counting convention: edge 1 is the first rising edge with reset low; that edge samples dur_cnt 0→1.
- audio rises first at edge 36, then toggles every 36 cycles while note 0 sounds.
- Note 0 is silent for edges 61–64 (gap).
- Note 1 starts at edge 64; note_start is high in the cycle after edge 64.
- Back-to-back identical notes (indices 4/5, 12/13) are separated by the gap plus a forced audio=0 at the boundary.
- The REST note (index 7) keeps audio low for its full 128 cycles.
- One melody pass is 1920 cycles. note_idx returns to 0 and loop_count becomes 1 at edge 1920.
- Latency from any counter condition to an audio change is 1 cycle (audio is registered).

## Structure
- Package rr_pkg holds:
  - pitch code constants;
  - the half-period lookup function (pitch → 8-bit);
  - the melody ROM function (index → {pitch, units});
  - NOTE_COUNT = 16.
- One sub-module, rr_tone_gen, is natural:
  - inputs: clock, reset, enable, half_period, restart;
  - outputs: audio, tone_cnt.
- rr_module holds the sequencer and instantiates rr_tone_gen.

## Test plan
- Reset for 1 cycle, then run 100 cycles -> audio rises at edge 36 and falls at edge 72. Wait: edge 72 is in note 1 after the clear at 64, so instead check audio = 1 from edge 36 to edge 60 and audio = 0 from edge 61.
- Note stepping over 640 cycles -> note_idx changes at edges 64, 128, 192, 256, 448 and 640; note_start pulses once per note.
- REST note -> audio stays 0 and tone_cnt stays 0 for 128 consecutive cycles after note 7 starts.
- F#5 note -> audio half-period is 21 cycles; audio is 0 for the last 4 cycles of note 4 and restarts at 0 when note 5 begins.
- Run 4000 cycles -> note_idx wraps 15→0 at edge 1920 (loop_count=1) and again at edge 3840 (loop_count=2).
- Assert reset for 1 cycle mid-note (e.g. at edge 300) -> on the next edge, note_idx=0, dur_cnt=0, audio=0, loop_count=0; the sequence then replays identically to the first pass.

Source files
------------

// File: rtl/rr_pkg.sv
// rr_pkg
//   Shared definitions for the RickRoll melody player:
//     - 3-bit pitch codes (P_REST .. P_A5)
//     - half_period(): pitch code -> half-period of the square wave, in cycles
//     - melody_rom():  melody index -> {pitch[2:0], units[2:0]}
//     - NOTE_COUNT:    number of entries in the melody ROM
package rr_pkg;

   localparam int NOTE_COUNT = 16;

   localparam logic [2:0] P_REST = 3'd0;
   localparam logic [2:0] P_A4   = 3'd1;
   localparam logic [2:0] P_B4   = 3'd2;
   localparam logic [2:0] P_CS5  = 3'd3;
   localparam logic [2:0] P_D5   = 3'd4;
   localparam logic [2:0] P_E5   = 3'd5;
   localparam logic [2:0] P_FS5  = 3'd6;
   localparam logic [2:0] P_A5   = 3'd7;

   // Half-period in clock cycles. REST returns 0; it is never used for
   // counting because the tone generator is disabled during a rest.
   function automatic logic [7:0] half_period(input logic [2:0] pitch);
      logic [7:0] hp;
      case (pitch)
         P_A4:    hp = 8'd36;
         P_B4:    hp = 8'd32;
         P_CS5:   hp = 8'd29;
         P_D5:    hp = 8'd27;
         P_E5:    hp = 8'd24;
         P_FS5:   hp = 8'd21;
         P_A5:    hp = 8'd18;
         default: hp = 8'd0;
      endcase
      return hp;
   endfunction

   // Melody ROM: {pitch, duration in units}. 30 units per pass.
   function automatic logic [5:0] melody_rom(input logic [3:0] idx);
      logic [5:0] w;
      case (idx)
         4'd0:    w = {P_A4,   3'd1};
         4'd1:    w = {P_B4,   3'd1};
         4'd2:    w = {P_D5,   3'd1};
         4'd3:    w = {P_B4,   3'd1};
         4'd4:    w = {P_FS5,  3'd3};
         4'd5:    w = {P_FS5,  3'd3};
         4'd6:    w = {P_E5,   3'd4};
         4'd7:    w = {P_REST, 3'd2};
         4'd8:    w = {P_A4,   3'd1};
         4'd9:    w = {P_B4,   3'd1};
         4'd10:   w = {P_D5,   3'd1};
         4'd11:   w = {P_B4,   3'd1};
         4'd12:   w = {P_E5,   3'd3};
         4'd13:   w = {P_E5,   3'd3};
         4'd14:   w = {P_D5,   3'd3};
         default: w = {P_CS5,  3'd1};
      endcase
      return w;
   endfunction

endpackage

// File: rtl/rr_tone_gen.sv
// rr_tone_gen
//   Square-wave generator. While enabled, counts cycles within the current
//   half-period and toggles audio each time a half-period completes.
//   Ports:
//     clock        in   rising-edge clock
//     reset        in   synchronous active-high reset
//     enable       in   1 = sounding phase, 0 = rest/gap (output held low)
//     restart      in   note boundary: clear counter and audio
//     half_period  in   half-period in cycles (8 bits)
//     audio        out  registered square-wave output
//     tone_cnt     out  cycle within the current half-period
module rr_tone_gen (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       restart,
   input  logic [7:0] half_period,
   output logic       audio,
   output logic [7:0] tone_cnt
);

   logic half_done;

   assign half_done = (tone_cnt == half_period - 8'd1);

   always_ff @(posedge clock) begin
      if (reset || restart) begin
         tone_cnt <= 8'd0;
         audio    <= 1'b0;
      end else if (enable) begin
         if (half_done) begin
            tone_cnt <= 8'd0;
            audio    <= ~audio;
         end else begin
            tone_cnt <= tone_cnt + 8'd1;
         end
      end else begin
         // Rest or articulation gap: silent, and the next sounding phase
         // starts from a fresh low half-period.
         tone_cnt <= 8'd0;
         audio    <= 1'b0;
      end
   end

endmodule

// File: rtl/rr_module.sv
// rr_module
//   Top of the RickRoll player: loops a 16-note phrase as a 1-bit square
//   wave. No data ports; behaviour is observed through internal signals
//   audio, note_idx, dur_cnt, tone_cnt, loop_count and note_start.
//   Parameters:
//     TICKS_PER_UNIT  clock cycles per duration unit
//     GAP_CYCLES      silent cycles at the end of each note (< TICKS_PER_UNIT)
//   Ports:
//     clock  in  rising-edge clock
//     reset  in  synchronous active-high reset
module rr_module
   import rr_pkg::*;
#(
   parameter int TICKS_PER_UNIT = 64,
   parameter int GAP_CYCLES     = 4
) (
   input logic clock,
   input logic reset
);

   localparam logic [11:0] TPU = 12'(TICKS_PER_UNIT);
   localparam logic [11:0] GAP = 12'(GAP_CYCLES);

   logic        audio;
   logic [3:0]  note_idx;
   logic [11:0] dur_cnt;
   logic [7:0]  tone_cnt;
   logic [7:0]  loop_count;
   logic        note_start;

   logic [5:0]  rom_word;
   logic [2:0]  pitch;
   logic [2:0]  units;
   logic [11:0] note_len;
   logic [11:0] sound_len;
   logic        note_end;
   logic        sounding;

   assign rom_word  = melody_rom(note_idx);
   assign pitch     = rom_word[5:3];
   assign units     = rom_word[2:0];
   assign note_len  = TPU * {9'd0, units};
   assign sound_len = note_len - GAP;

   assign note_end   = (dur_cnt == note_len - 12'd1);
   assign sounding   = (pitch != P_REST) && (dur_cnt < sound_len);
   assign note_start = (dur_cnt == 12'd0);

   // Sequencer: walks the ROM, one note every note_len cycles.
   always_ff @(posedge clock) begin
      if (reset) begin
         note_idx   <= 4'd0;
         dur_cnt    <= 12'd0;
         loop_count <= 8'd0;
      end else if (note_end) begin
         dur_cnt  <= 12'd0;
         note_idx <= note_idx + 4'd1;
         if (note_idx == 4'(NOTE_COUNT - 1)) begin
            loop_count <= loop_count + 8'd1;
         end
      end else begin
         dur_cnt <= dur_cnt + 12'd1;
      end
   end

   // restart on note_end forces audio low at every note boundary, so two
   // identical consecutive notes are still heard as separate notes.
   rr_tone_gen u_tone (
      .clock       (clock),
      .reset       (reset),
      .enable      (sounding),
      .restart     (note_end),
      .half_period (half_period(pitch)),
      .audio       (audio),
      .tone_cnt    (tone_cnt)
   );

endmodule

// File: tb/tb_rr_module.sv
module tb_rr_module;

   logic clock;
   logic reset;

   rr_module #(.TICKS_PER_UNIT(64), .GAP_CYCLES(4)) dut (
      .clock (clock),
      .reset (reset)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Signal selectors
   localparam int S_AUDIO = 0;
   localparam int S_IDX   = 1;
   localparam int S_DUR   = 2;
   localparam int S_TONE  = 3;
   localparam int S_LOOP  = 4;
   localparam int S_START = 5;

   // Absolute edge numbers: reset released after edge R, so design edge n
   // of the first pass is absolute edge R+n. Mid-run reset is sampled at
   // absolute edge R2, which becomes edge 0 of the replay.
   localparam int R  = 2;
   localparam int R2 = R + 4140;
   localparam int LAST = R2 + 1000;

   typedef struct {
      int    at_cyc;
      int    sig;
      int    val;
      string nm;
   } exp_t;

   exp_t sb[$];
   int   abs_cyc = 0;
   int   total = 0;
   int   bad = 0;

   always @(posedge clock) abs_cyc <= abs_cyc + 1;

   function automatic int probe(input int s);
      case (s)
         S_AUDIO: return int'(dut.audio);
         S_IDX:   return int'(dut.note_idx);
         S_DUR:   return int'(dut.dur_cnt);
         S_TONE:  return int'(dut.tone_cnt);
         S_LOOP:  return int'(dut.loop_count);
         default: return int'(dut.note_start);
      endcase
   endfunction

   task automatic chk(input int base, input int n, input int s, input int v,
                      input string nm);
      exp_t e;
      e.at_cyc = base + n;
      e.sig    = s;
      e.val    = v;
      e.nm     = nm;
      sb.push_back(e);
   endtask

   // Monitor: state after absolute edge k is sampled on the following
   // falling edge and compared with every expectation due at k.
   always @(negedge clock) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].at_cyc == abs_cyc) begin
            int act;
            act = probe(sb[i].sig);
            total++;
            if (act != sb[i].val) begin
               bad++;
               $display("FAIL %s at abs edge %0d: got %0d expected %0d",
                        sb[i].nm, abs_cyc, act, sb[i].val);
            end
            sb.delete(i);
         end else if (sb[i].at_cyc < abs_cyc) begin
            total++;
            bad++;
            $display("FAIL %s: expectation for abs edge %0d never checked",
                     sb[i].nm, sb[i].at_cyc);
            sb.delete(i);
         end
      end
   end

   initial begin
      reset = 1'b1;

      // ---- first pass, edges relative to R ----
      chk(R, 0, S_IDX,   0, "rst_idx");
      chk(R, 0, S_DUR,   0, "rst_dur");
      chk(R, 0, S_TONE,  0, "rst_tone");
      chk(R, 0, S_AUDIO, 0, "rst_audio");
      chk(R, 0, S_LOOP,  0, "rst_loop");
      chk(R, 0, S_START, 1, "rst_start");
      chk(R, 1, S_DUR,   1, "dur_e1");
      chk(R, 1, S_START, 0, "start_e1");
      // note 0, A4 (half 36)
      chk(R, 35, S_AUDIO, 0, "a4_e35_audio");
      chk(R, 35, S_TONE, 35, "a4_e35_tone");
      chk(R, 36, S_AUDIO, 1, "a4_rise");
      chk(R, 36, S_TONE,  0, "a4_tone_clr");
      chk(R, 60, S_AUDIO, 1, "a4_e60_audio");
      chk(R, 60, S_DUR,  60, "a4_e60_dur");
      chk(R, 61, S_AUDIO, 0, "a4_gap_audio");
      chk(R, 61, S_TONE,  0, "a4_gap_tone");
      chk(R, 63, S_IDX,   0, "idx_e63");
      chk(R, 63, S_START, 0, "start_e63");
      // note stepping
      chk(R, 64, S_IDX,   1, "idx_e64");
      chk(R, 64, S_DUR,   0, "dur_e64");
      chk(R, 64, S_START, 1, "start_e64");
      chk(R, 65, S_START, 0, "start_e65");
      chk(R, 128, S_IDX,  2, "idx_e128");
      chk(R, 192, S_IDX,  3, "idx_e192");
      chk(R, 256, S_IDX,  4, "idx_e256");
      chk(R, 447, S_IDX,  4, "idx_e447");
      chk(R, 448, S_IDX,  5, "idx_e448");
      chk(R, 639, S_IDX,  5, "idx_e639");
      chk(R, 640, S_IDX,  6, "idx_e640");
      // note 4, F#5 (half 21), starts after edge 256
      chk(R, 276, S_AUDIO, 0, "fs5_e276");
      chk(R, 277, S_AUDIO, 1, "fs5_rise");
      chk(R, 297, S_AUDIO, 1, "fs5_e297");
      chk(R, 298, S_AUDIO, 0, "fs5_fall");
      chk(R, 423, S_AUDIO, 1, "fs5_e423");
      chk(R, 423, S_TONE, 20, "fs5_e423_tone");
      chk(R, 444, S_DUR, 188, "fs5_e444_dur");
      chk(R, 444, S_TONE, 20, "fs5_e444_tone");
      chk(R, 445, S_AUDIO, 0, "fs5_gap_audio");
      chk(R, 445, S_TONE,  0, "fs5_gap_tone");
      chk(R, 448, S_AUDIO, 0, "fs5_boundary_audio");
      chk(R, 448, S_TONE,  0, "fs5_boundary_tone");
      chk(R, 449, S_TONE,  1, "fs5b_e449_tone");
      chk(R, 468, S_AUDIO, 0, "fs5b_e468");
      chk(R, 469, S_AUDIO, 1, "fs5b_rise");
      // note 7, REST: silent for its whole length
      chk(R, 896, S_IDX, 7, "rest_idx");
      for (int n = 897; n <= 1023; n++) begin
         chk(R, n, S_AUDIO, 0, "rest_audio");
         chk(R, n, S_TONE,  0, "rest_tone");
      end
      chk(R, 1024, S_IDX, 8, "idx_e1024");
      // wraps
      chk(R, 1919, S_IDX, 15, "idx_e1919");
      chk(R, 1919, S_LOOP, 0, "loop_e1919");
      chk(R, 1920, S_IDX,  0, "wrap1_idx");
      chk(R, 1920, S_LOOP, 1, "wrap1_loop");
      chk(R, 1920, S_DUR,  0, "wrap1_dur");
      chk(R, 1956, S_AUDIO, 1, "pass2_rise");
      chk(R, 3839, S_IDX, 15, "idx_e3839");
      chk(R, 3840, S_IDX,  0, "wrap2_idx");
      chk(R, 3840, S_LOOP, 2, "wrap2_loop");
      // just before the mid-run reset: 299 cycles into pass 3 (note 4)
      chk(R, 4139, S_IDX,  4, "pre_rst_idx");
      chk(R, 4139, S_DUR, 43, "pre_rst_dur");
      chk(R, 4139, S_LOOP, 2, "pre_rst_loop");

      // ---- replay after mid-run reset, edges relative to R2 ----
      chk(R2, 0, S_IDX,   0, "mrst_idx");
      chk(R2, 0, S_DUR,   0, "mrst_dur");
      chk(R2, 0, S_AUDIO, 0, "mrst_audio");
      chk(R2, 0, S_TONE,  0, "mrst_tone");
      chk(R2, 0, S_LOOP,  0, "mrst_loop");
      chk(R2, 35, S_AUDIO, 0, "re_e35");
      chk(R2, 36, S_AUDIO, 1, "re_rise");
      chk(R2, 61, S_AUDIO, 0, "re_gap");
      chk(R2, 64, S_IDX,   1, "re_idx_e64");
      chk(R2, 277, S_AUDIO, 1, "re_fs5_rise");
      chk(R2, 448, S_IDX,  5, "re_idx_e448");
      chk(R2, 1000, S_IDX, 7, "re_rest_idx");
      chk(R2, 1000, S_AUDIO, 0, "re_rest_audio");

      // release reset after edge R
      while (abs_cyc < R) @(negedge clock);
      reset = 1'b0;

      // one-cycle reset sampled at absolute edge R2
      while (abs_cyc < R2 - 1) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;

      while (abs_cyc < LAST + 2) @(negedge clock);

      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL leftover: %0d expectations unchecked, required 0",
                  sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
